// File: rtl/pong_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_timing_pkg
// Description : VGA 640x480 timing constants, position field width, the
//               scheduler state encoding and the position record used by
//               the frame-synchronous update scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned POS_W    = 10;

  // Scheduler states (2-bit encoding kept stable for downstream tools)
  localparam logic [1:0] S_ACTIVE = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_MISS   = 2'd3;

  typedef struct packed {
    logic [POS_W-1:0] ball_x;
    logic [POS_W-1:0] ball_y;
    logic [POS_W-1:0] padl_y;
    logic [POS_W-1:0] padr_y;
  } pos_t;

  // Largest on-screen coordinate per axis; loads above these are clamped
  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACTIVE - 1);

  // Everything starts centred on screen
  localparam pos_t POS_RESET = '{
    ball_x: POS_W'(H_ACTIVE / 2),
    ball_y: POS_W'(V_ACTIVE / 2),
    padl_y: POS_W'(V_ACTIVE / 2),
    padr_y: POS_W'(V_ACTIVE / 2)
  };

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] val,
                                                 input logic [POS_W-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage : pong_timing_pkg
`default_nettype wire

// File: rtl/pos_shadow_reg.sv
`default_nettype none
// ============================================================================
// Module      : pos_shadow_reg
// Description : Four-field position double buffer. load_i captures clamped
//               inputs into the shadow copy; commit_i publishes the shadow
//               copy to the live outputs. Both copies reset to screen centre.
// Revision    : 1.0 - initial release
// ============================================================================
module pos_shadow_reg
  import pong_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             commit_i,
  input  logic [POS_W-1:0] ball_x_i,
  input  logic [POS_W-1:0] ball_y_i,
  input  logic [POS_W-1:0] padl_y_i,
  input  logic [POS_W-1:0] padr_y_i,
  output logic [POS_W-1:0] ball_x_o,
  output logic [POS_W-1:0] ball_y_o,
  output logic [POS_W-1:0] padl_y_o,
  output logic [POS_W-1:0] padr_y_o
);

  pos_t shadow_q;
  pos_t shadow_d;
  pos_t live_q;

  // Clamp on load so the renderer never sees an off-screen coordinate
  always_comb begin
    shadow_d = shadow_q;
    if (load_i) begin
      shadow_d.ball_x = clamp_pos(ball_x_i, X_MAX);
      shadow_d.ball_y = clamp_pos(ball_y_i, Y_MAX);
      shadow_d.padl_y = clamp_pos(padl_y_i, Y_MAX);
      shadow_d.padr_y = clamp_pos(padr_y_i, Y_MAX);
    end
  end

  // Shadow follows loads; live copy only moves on a commit strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= POS_RESET;
      live_q   <= POS_RESET;
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) begin
        live_q <= shadow_q;
      end
    end
  end

  assign ball_x_o = live_q.ball_x;
  assign ball_y_o = live_q.ball_y;
  assign padl_y_o = live_q.padl_y;
  assign padr_y_o = live_q.padr_y;

endmodule : pos_shadow_reg
`default_nettype wire

// File: rtl/frame_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : frame_update_sched
// Description : Frame-synchronous scheduler between the VGA counters and the
//               Pong game logic. Requests one position update per frame at
//               vblank start, shadow-latches the answer and commits it at
//               end-of-frame for tear-free motion. Late updates are counted.
//               Optional feature macro: FRAME_MISS_CNT_EN (missed-update
//               counter; when undefined miss_cnt is tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_update_sched
  import pong_timing_pkg::*;
#(
  parameter int unsigned DEADLINE_LINE = 520
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             upd_ack,
  input  logic [POS_W-1:0] ball_x_in,
  input  logic [POS_W-1:0] ball_y_in,
  input  logic [POS_W-1:0] padl_y_in,
  input  logic [POS_W-1:0] padr_y_in,
  output logic             upd_req,
  output logic [POS_W-1:0] ball_x,
  output logic [POS_W-1:0] ball_y,
  output logic [POS_W-1:0] padl_y,
  output logic [POS_W-1:0] padr_y,
  output logic             in_vblank,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       miss_cnt
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [15:0] frame_cnt_q;
  logic        in_vblank_q;
  logic        w_vstart;
  logic        w_dead;
  logic        w_eof;
  logic        w_load;
  logic        w_commit;
  logic        w_frame_inc;

  // Timing trigger points; all qualified by the pixel enable
  assign w_vstart = pix_en && (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));
  assign w_dead   = pix_en && (h_count == 10'd0) && (v_count == 10'(DEADLINE_LINE));
  assign w_eof    = pix_en && (h_count == 10'(H_TOTAL - 1))
                           && (v_count == 10'(V_TOTAL - 1));

  // Next-state decode; the ack is sampled every clock while requesting and
  // beats a coincident deadline
  always_comb begin
    state_d     = state_q;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_frame_inc = 1'b0;
    case (state_q)
      S_ACTIVE: begin
        if (w_vstart) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (upd_ack) begin
          w_load  = 1'b1;
          state_d = S_HOLD;
        end else if (w_dead) begin
          state_d = S_MISS;
        end else if (w_eof) begin
          // Deadline slipped past unseen: close the frame as a miss
          w_frame_inc = 1'b1;
          state_d     = S_ACTIVE;
        end
      end
      S_HOLD: begin
        if (w_eof) begin
          w_commit    = 1'b1;
          w_frame_inc = 1'b1;
          state_d     = S_ACTIVE;
        end
      end
      S_MISS: begin
        if (w_eof) begin
          w_frame_inc = 1'b1;
          state_d     = S_ACTIVE;
        end
      end
      default: state_d = S_ACTIVE;
    endcase
  end

  // State, frame counter and vblank flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACTIVE;
      frame_cnt_q <= 16'd0;
      in_vblank_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_vblank_q <= (v_count >= 10'(V_ACTIVE));
      if (w_frame_inc) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Request window is exactly the time spent in S_REQ
  assign upd_req   = (state_q == S_REQ);
  assign in_vblank = in_vblank_q;
  assign frame_cnt = frame_cnt_q;

`ifdef FRAME_MISS_CNT_EN
  logic [7:0] miss_cnt_q;
  logic       w_miss_evt;

  // A miss closes at EOF, either from S_MISS or straight out of S_REQ
  assign w_miss_evt = w_eof && ((state_q == S_MISS) ||
                                ((state_q == S_REQ) && !upd_ack));

  // Saturating missed-update counter
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= 8'd0;
    end else if (w_miss_evt && (miss_cnt_q != 8'hFF)) begin
      miss_cnt_q <= miss_cnt_q + 8'd1;
    end
  end

  assign miss_cnt = miss_cnt_q;
`else
  assign miss_cnt = 8'd0;
`endif

  pos_shadow_reg u_pos_shadow_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (w_load),
    .commit_i (w_commit),
    .ball_x_i (ball_x_in),
    .ball_y_i (ball_y_in),
    .padl_y_i (padl_y_in),
    .padr_y_i (padr_y_in),
    .ball_x_o (ball_x),
    .ball_y_o (ball_y),
    .padl_y_o (padl_y),
    .padr_y_o (padr_y)
  );

endmodule : frame_update_sched
`default_nettype wire

// File: tb/tb_frame_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_update_sched
// Description : Directed self-checking bench for frame_update_sched. The h/v
//               counters are driven directly so each frame only visits its
//               trigger points. Honours FRAME_MISS_CNT_EN for miss_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_update_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       upd_ack;
  logic [9:0] ball_x_in, ball_y_in, padl_y_in, padr_y_in;
  logic       upd_req;
  logic [9:0] ball_x, ball_y, padl_y, padr_y;
  logic       in_vblank;
  logic [15:0] frame_cnt;
  logic [7:0]  miss_cnt;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FRAME_MISS_CNT_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  frame_update_sched dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .h_count   (h_count),
    .v_count   (v_count),
    .upd_ack   (upd_ack),
    .ball_x_in (ball_x_in),
    .ball_y_in (ball_y_in),
    .padl_y_in (padl_y_in),
    .padr_y_in (padr_y_in),
    .upd_req   (upd_req),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .padl_y    (padl_y),
    .padr_y    (padr_y),
    .in_vblank (in_vblank),
    .frame_cnt (frame_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Expected miss count for n misses since reset
  function automatic logic [31:0] exp_miss(input int n);
    if (!MISS_EN) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  // Present inputs, let one rising edge sample them, observe 1 ns later
  task automatic cyc(input logic [9:0] h, input logic [9:0] v,
                     input logic pe, input logic ack);
    h_count = h;
    v_count = v;
    pix_en  = pe;
    upd_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [9:0] bx, input logic [9:0] by,
                        input logic [9:0] pl, input logic [9:0] pr);
    ball_x_in = bx;
    ball_y_in = by;
    padl_y_in = pl;
    padr_y_in = pr;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input logic [9:0] bx, input logic [9:0] by,
                         input logic [9:0] pl, input logic [9:0] pr);
    chk({tag, ".ball_x"}, 32'(ball_x), 32'(bx));
    chk({tag, ".ball_y"}, 32'(ball_y), 32'(by));
    chk({tag, ".padl_y"}, 32'(padl_y), 32'(pl));
    chk({tag, ".padr_y"}, 32'(padr_y), 32'(pr));
  endtask

  initial begin
    rst = 1'b1;
    set_in(10'd0, 10'd0, 10'd0, 10'd0);
    cyc(10'd1, 10'd1, 1'b1, 1'b0);
    cyc(10'd1, 10'd1, 1'b1, 1'b0);
    cyc(10'd1, 10'd1, 1'b1, 1'b0);

    // Reset state
    chk("rst.upd_req", 32'(upd_req), 32'd0);
    chk("rst.in_vblank", 32'(in_vblank), 32'd0);
    chk("rst.frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst.miss_cnt", 32'(miss_cnt), 32'd0);
    chk_pos("rst", 10'd320, 10'd240, 10'd240, 10'd240);
    rst = 1'b0;

    // No request without pix_en at the vblank-start position
    cyc(10'd0, 10'd480, 1'b0, 1'b0);
    chk("nopix.upd_req", 32'(upd_req), 32'd0);

    // 1: ack three clocks after the request opens
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    chk("t1.upd_req_open", 32'(upd_req), 32'd1);
    chk("t1.in_vblank", 32'(in_vblank), 32'd1);
    cyc(10'd1, 10'd480, 1'b1, 1'b0);
    cyc(10'd2, 10'd480, 1'b1, 1'b0);
    set_in(10'd100, 10'd50, 10'd200, 10'd300);
    cyc(10'd3, 10'd480, 1'b1, 1'b1);
    chk("t1.upd_req_drop", 32'(upd_req), 32'd0);
    chk("t1.ball_x_pre", 32'(ball_x), 32'd320);
    cyc(10'd799, 10'd524, 1'b0, 1'b0);
    chk("t1.ball_x_eof_gated", 32'(ball_x), 32'd320);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk_pos("t1", 10'd100, 10'd50, 10'd200, 10'd300);
    chk("t1.frame_cnt", 32'(frame_cnt), 32'd1);
    chk("t1.miss_cnt", 32'(miss_cnt), 32'd0);

    // Ack outside the request window is ignored
    set_in(10'd5, 10'd5, 10'd5, 10'd5);
    cyc(10'd1, 10'd1, 1'b1, 1'b1);
    chk("stray_ack.upd_req", 32'(upd_req), 32'd0);
    chk("stray_ack.in_vblank", 32'(in_vblank), 32'd0);

    // 2: never ack; deadline closes the window, positions held
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    chk("t2.upd_req_open", 32'(upd_req), 32'd1);
    cyc(10'd0, 10'd520, 1'b0, 1'b0);
    chk("t2.dead_gated", 32'(upd_req), 32'd1);
    cyc(10'd0, 10'd520, 1'b1, 1'b0);
    chk("t2.upd_req_dead", 32'(upd_req), 32'd0);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk_pos("t2", 10'd100, 10'd50, 10'd200, 10'd300);
    chk("t2.frame_cnt", 32'(frame_cnt), 32'd2);
    chk("t2.miss_cnt", 32'(miss_cnt), exp_miss(1));

    // 3: ack coincident with the deadline wins
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    set_in(10'd10, 10'd20, 10'd30, 10'd40);
    cyc(10'd0, 10'd520, 1'b1, 1'b1);
    chk("t3.upd_req", 32'(upd_req), 32'd0);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk_pos("t3", 10'd10, 10'd20, 10'd30, 10'd40);
    chk("t3.frame_cnt", 32'(frame_cnt), 32'd3);
    chk("t3.miss_cnt", 32'(miss_cnt), exp_miss(1));

    // 4: clamp on load at and beyond the screen edge
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    set_in(10'd700, 10'd480, 10'd600, 10'd479);
    cyc(10'd5, 10'd490, 1'b1, 1'b1);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk_pos("t4", 10'd639, 10'd479, 10'd479, 10'd479);
    chk("t4.frame_cnt", 32'(frame_cnt), 32'd4);

    // 5: reset in the middle of a handshake
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    chk("t5.upd_req_open", 32'(upd_req), 32'd1);
    rst = 1'b1;
    cyc(10'd1, 10'd481, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t5.upd_req_rst", 32'(upd_req), 32'd0);
    chk("t5.in_vblank_rst", 32'(in_vblank), 32'd0);
    chk("t5.frame_cnt_rst", 32'(frame_cnt), 32'd0);
    chk("t5.miss_cnt_rst", 32'(miss_cnt), 32'd0);
    chk_pos("t5.rst", 10'd320, 10'd240, 10'd240, 10'd240);
    set_in(10'd1, 10'd2, 10'd3, 10'd4);
    cyc(10'd2, 10'd481, 1'b1, 1'b1);
    chk("t5.no_req_after_rst", 32'(upd_req), 32'd0);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk_pos("t5.no_commit", 10'd320, 10'd240, 10'd240, 10'd240);
    chk("t5.frame_cnt_idle", 32'(frame_cnt), 32'd0);
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    chk("t5.next_req", 32'(upd_req), 32'd1);
    cyc(10'd1, 10'd480, 1'b1, 1'b1);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk_pos("t5.commit", 10'd1, 10'd2, 10'd3, 10'd4);
    chk("t5.frame_cnt", 32'(frame_cnt), 32'd1);

    // EOF reached while still requesting counts as a miss
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk("eofreq.upd_req", 32'(upd_req), 32'd0);
    chk_pos("eofreq", 10'd1, 10'd2, 10'd3, 10'd4);
    chk("eofreq.frame_cnt", 32'(frame_cnt), 32'd2);
    chk("eofreq.miss_cnt", 32'(miss_cnt), exp_miss(1));

    // 6: 300 missed frames saturate the miss counter
    for (int i = 0; i < 300; i++) begin
      cyc(10'd0, 10'd480, 1'b1, 1'b0);
      cyc(10'd0, 10'd520, 1'b1, 1'b0);
      cyc(10'd799, 10'd524, 1'b1, 1'b0);
    end
    chk("t6.miss_cnt_sat", 32'(miss_cnt), exp_miss(301));
    chk("t6.frame_cnt", 32'(frame_cnt), 32'd302);
    chk_pos("t6", 10'd1, 10'd2, 10'd3, 10'd4);

    // Frame counter wrap from 0xFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    cyc(10'd1, 10'd1, 1'b1, 1'b0);
    release dut.frame_cnt_q;
    chk("wrap.pre", 32'(frame_cnt), 32'hFFFF);
    cyc(10'd0, 10'd480, 1'b1, 1'b0);
    cyc(10'd799, 10'd524, 1'b1, 1'b0);
    chk("wrap.frame_cnt", 32'(frame_cnt), 32'd0);
    chk("wrap.miss_cnt", 32'(miss_cnt), exp_miss(302));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_frame_update_sched
`default_nettype wire
